// File: rtl/ahb_slave_if_gen2_if.sv
// AHB slave-side bus plus downstream request/response channel of the AHB-to-APB bridge front end.
// The slave modport is the bridge; the master modport is whatever drives AHB and consumes requests.
interface ahb_slave_if_gen2_if #(
    parameter int DATA_W  = 32,
    parameter int NUM_SLV = 3
);
    logic              Hwrite;
    logic              Hreadyin;
    logic [1:0]        Htrans;
    logic [31:0]       Haddr;
    logic [DATA_W-1:0] Hwdata;
    logic              Hreadyout;
    logic [1:0]        Hresp;
    logic [DATA_W-1:0] Hrdata;

    logic               req_valid;
    logic               req_ready;
    logic               req_write;
    logic [31:0]        req_addr;
    logic [DATA_W-1:0]  req_wdata;
    logic [NUM_SLV-1:0] req_sel;
    logic               rsp_valid;
    logic [DATA_W-1:0]  rsp_rdata;

    modport slave (
        input  Hwrite, Hreadyin, Htrans, Haddr, Hwdata, req_ready, rsp_valid, rsp_rdata,
        output Hreadyout, Hresp, Hrdata, req_valid, req_write, req_addr, req_wdata, req_sel
    );

    modport master (
        output Hwrite, Hreadyin, Htrans, Haddr, Hwdata, req_ready, rsp_valid, rsp_rdata,
        input  Hreadyout, Hresp, Hrdata, req_valid, req_write, req_addr, req_wdata, req_sel
    );
endinterface

// File: rtl/ahb_slave_if_gen2.sv
// AHB slave decoding NUM_SLV regions into a posted request queue; writes complete zero-wait unless the queue is full.
// Reads stall until the queue drains ahead of them and rsp_valid returns data; a full queue adds AHB wait states.
module ahb_slave_if_gen2 #(
    parameter int          NUM_SLV     = 3,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          REGION_LOG2 = 26,
    parameter int          DATA_W      = 32,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic               Hclk,
    input  logic               Hresetn,
    ahb_slave_if_gen2_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [31:0]        addr;
        logic [DATA_W-1:0]  wdata;
        logic [NUM_SLV-1:0] sel;
        logic               write;
    } req_t;

    typedef enum logic [2:0] {IDLE, WDATA, RD_Q, RD_W, RD_DONE, ERR1, ERR2} state_t;

    state_t             state;
    logic [31:0]        addr_q;
    logic [NUM_SLV-1:0] sel_q;
    logic [DATA_W-1:0]  rdata_q;

    req_t               mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full, empty, push, pop;
    req_t               push_dat, head;

    logic [31:0]        off, idx;
    logic               mapped, xfer, accept;
    logic [NUM_SLV-1:0] sel_d;

    always_comb begin
        off    = bus.Haddr - BASE_ADDR;
        idx    = off >> REGION_LOG2;
        mapped = (bus.Haddr >= BASE_ADDR) && (idx < 32'(NUM_SLV));
        sel_d  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            sel_d[i] = mapped && (idx == 32'(i));
        end
    end

    assign xfer  = bus.Hreadyin && (bus.Htrans == 2'b10 || bus.Htrans == 2'b11);
    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign pop   = !empty && bus.req_ready;
    assign push  = (state == WDATA || state == RD_Q) && !full;

    // A stalled write data phase is not an address-accepting cycle: the master is held by Hreadyout=0.
    assign accept = (state == IDLE) || (state == RD_DONE) || (state == ERR2) ||
                    (state == WDATA && !full);

    always_comb begin
        push_dat.addr  = addr_q;
        push_dat.wdata = (state == WDATA) ? bus.Hwdata : '0;
        push_dat.sel   = sel_q;
        push_dat.write = (state == WDATA);
    end

    always_ff @(posedge Hclk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state   <= IDLE;
            addr_q  <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
        end else if (accept) begin
            if (xfer) begin
                addr_q <= bus.Haddr;
                sel_q  <= sel_d;
                if (!mapped)         state <= ERR1;
                else if (bus.Hwrite) state <= WDATA;
                else                 state <= RD_Q;
            end else begin
                state <= IDLE;
            end
        end else begin
            case (state)
                RD_Q: if (!full) state <= RD_W;
                RD_W: if (bus.rsp_valid) begin
                    rdata_q <= bus.rsp_rdata;
                    state   <= RD_DONE;
                end
                ERR1:    state <= ERR2;
                default: state <= state;
            endcase
        end
    end

    always_comb begin
        case (state)
            WDATA:       bus.Hreadyout = !full;
            RD_Q, RD_W:  bus.Hreadyout = 1'b0;
            ERR1:        bus.Hreadyout = 1'b0;
            default:     bus.Hreadyout = 1'b1;
        endcase
    end

    assign bus.Hresp  = (state == ERR1 || state == ERR2) ? 2'b01 : 2'b00;
    assign bus.Hrdata = rdata_q;

    // Head fields are forced to zero when empty so stale entries never appear downstream.
    assign head          = mem[rd_ptr];
    assign bus.req_valid = !empty;
    assign bus.req_write = empty ? 1'b0 : head.write;
    assign bus.req_addr  = empty ? '0 : head.addr;
    assign bus.req_wdata = empty ? '0 : head.wdata;
    assign bus.req_sel   = empty ? '0 : head.sel;
endmodule
